// File: rtl/shift_lpc_if.sv
// shift_lpc_if: bundles the PC-to-byte-address conversion signals.
//   pc           word-index program counter (driven by master)
//   pc_valid     qualifies pc for the registered path (driven by master)
//   realPC       combinational byte address (driven by slave)
//   realPC_q     registered byte address (driven by slave)
//   realPC_vld   realPC_q holds a fresh result this cycle (driven by slave)
//   out_of_range registered flag, realPC_q beyond the legal limit (driven by slave)
interface shift_lpc_if #(
    parameter int unsigned PC_W  = 12,
    parameter int unsigned OUT_W = 16
);
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic [OUT_W-1:0] realPC;
    logic [OUT_W-1:0] realPC_q;
    logic             realPC_vld;
    logic             out_of_range;

    modport master (
        output pc, pc_valid,
        input  realPC, realPC_q, realPC_vld, out_of_range
    );

    modport slave (
        input  pc, pc_valid,
        output realPC, realPC_q, realPC_vld, out_of_range
    );
endinterface

// File: rtl/shift_lpc.sv
// shift_lpc: converts a word-index PC into a byte address by a left shift.
//   clk          sole clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          shift_lpc_if slave modport:
//                  pc/pc_valid in; realPC (combinational), realPC_q,
//                  realPC_vld, out_of_range (registered) out
module shift_lpc #(
    parameter int unsigned      PC_W       = 12,
    parameter int unsigned      OUT_W      = 16,
    parameter int unsigned      SHIFT      = 2,
    parameter logic [OUT_W-1:0] ADDR_LIMIT = 16'h3FFC
) (
    input  logic        clk,
    input  logic        rst_n,
    shift_lpc_if.slave  bus
);

    if (PC_W + SHIFT > OUT_W) begin : gBadParams
        $fatal(1, "shift_lpc: PC_W + SHIFT must not exceed OUT_W");
    end

    logic [OUT_W-1:0] byteAddr;

    // Zero-extend first so the shift never loses bits inside OUT_W.
    assign byteAddr   = OUT_W'(bus.pc) << SHIFT;
    assign bus.realPC = byteAddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.realPC_q     <= '0;
            bus.realPC_vld   <= 1'b0;
            bus.out_of_range <= 1'b0;
        end else if (bus.pc_valid) begin
            bus.realPC_q     <= byteAddr;
            bus.realPC_vld   <= 1'b1;
            bus.out_of_range <= (byteAddr > ADDR_LIMIT);
        end else begin
            bus.realPC_vld   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_lpc.sv
module tb_shift_lpc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] pc = '0;
    logic        pcValid = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference state: what the registered outputs must hold.
    logic [15:0] mQ = '0;
    logic        mVld = 1'b0;
    logic        mOorA = 1'b0;
    logic        mOorB = 1'b0;

    shift_lpc_if #(.PC_W(12), .OUT_W(16)) busA ();
    shift_lpc_if #(.PC_W(12), .OUT_W(16)) busB ();

    assign busA.pc       = pc;
    assign busA.pc_valid = pcValid;
    assign busB.pc       = pc;
    assign busB.pc_valid = pcValid;

    shift_lpc #(.PC_W(12), .OUT_W(16), .SHIFT(2), .ADDR_LIMIT(16'h3FFC)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    shift_lpc #(.PC_W(12), .OUT_W(16), .SHIFT(2), .ADDR_LIMIT(16'h0FFC)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    initial begin
        #20;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: byte address is pc * 4 modulo 2^16; limits compared numerically.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mQ    = '0;
            mVld  = 1'b0;
            mOorA = 1'b0;
            mOorB = 1'b0;
        end else if (pcValid) begin
            mQ    = 16'((int'(pc) * 4) % 65536);
            mVld  = 1'b1;
            mOorA = (int'(mQ) > 16380);
            mOorB = (int'(mQ) > 4092);
        end else begin
            mVld  = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp realPC A",  32'(busA.realPC), 32'((int'(pc) * 4) % 65536));
        chk("cmp realPC B",  32'(busB.realPC), 32'((int'(pc) * 4) % 65536));
        chk("cmp realPC_q A", 32'(busA.realPC_q), 32'(mQ));
        chk("cmp realPC_q B", 32'(busB.realPC_q), 32'(mQ));
        chk("cmp vld A", 32'(busA.realPC_vld), 32'(mVld));
        chk("cmp vld B", 32'(busB.realPC_vld), 32'(mVld));
        chk("cmp oor A", 32'(busA.out_of_range), 32'(mOorA));
        chk("cmp oor B", 32'(busB.out_of_range), 32'(mOorB));
    end

    initial begin
        logic [15:0] streamExp [4];
        streamExp[0] = 16'h0000;
        streamExp[1] = 16'h0004;
        streamExp[2] = 16'h0008;
        streamExp[3] = 16'h000C;

        // No clock yet: combinational path and reset values.
        pc = 12'h123;
        pcValid = 1'b1;
        #10;
        chk("noclk realPC", 32'(busA.realPC), 32'h048C);
        chk("reset q", 32'(busA.realPC_q), 32'h0);
        chk("reset vld", 32'(busA.realPC_vld), 32'h0);
        chk("reset oor", 32'(busA.out_of_range), 32'h0);

        // pc_valid during reset is ignored.
        repeat (2) step();
        chk("rst ignore vld", 32'(busA.realPC_vld), 32'h0);
        chk("rst ignore q", 32'(busA.realPC_q), 32'h0);

        rst_n = 1'b1;
        step();
        chk("first cap q", 32'(busA.realPC_q), 32'h048C);
        chk("first cap vld", 32'(busA.realPC_vld), 32'h1);
        pcValid = 1'b0;
        pc = 12'hABC;
        #1;
        chk("realPC ABC", 32'(busA.realPC), 32'h2AF0);
        step();
        chk("idle vld", 32'(busA.realPC_vld), 32'h0);
        chk("idle hold q", 32'(busA.realPC_q), 32'h048C);

        // Back-to-back stream.
        pcValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pc = 12'(i);
            step();
            chk("stream q", 32'(busA.realPC_q), 32'(streamExp[i]));
            chk("stream vld", 32'(busA.realPC_vld), 32'h1);
        end

        // Limit boundaries.
        pc = 12'hFFF;
        step();
        chk("FFF q", 32'(busA.realPC_q), 32'h3FFC);
        chk("FFF oor A", 32'(busA.out_of_range), 32'h0);
        chk("FFF oor B", 32'(busB.out_of_range), 32'h1);
        pc = 12'h400;
        step();
        chk("400 q", 32'(busB.realPC_q), 32'h1000);
        chk("400 oor B", 32'(busB.out_of_range), 32'h1);
        chk("400 oor A", 32'(busA.out_of_range), 32'h0);
        pcValid = 1'b0;
        pc = 12'h3FF;
        step();
        chk("hold oor B", 32'(busB.out_of_range), 32'h1);
        chk("hold q B", 32'(busB.realPC_q), 32'h1000);
        pcValid = 1'b1;
        step();
        chk("3FF q", 32'(busB.realPC_q), 32'h0FFC);
        chk("3FF oor B", 32'(busB.out_of_range), 32'h0);
        pc = 12'h000;
        #1;
        chk("realPC 000", 32'(busA.realPC), 32'h0000);
        pc = 12'hFFF;
        step();

        // Asynchronous reset between edges while a result is valid.
        chk("pre-rst vld", 32'(busB.realPC_vld), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async q", 32'(busB.realPC_q), 32'h0);
        chk("async vld", 32'(busB.realPC_vld), 32'h0);
        chk("async oor", 32'(busB.out_of_range), 32'h0);
        chk("rst realPC", 32'(busA.realPC), 32'h3FFC);
        step();
        pcValid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post-rst vld", 32'(busA.realPC_vld), 32'h0);
        chk("post-rst q", 32'(busA.realPC_q), 32'h0);

        // Randomized traffic with occasional mid-stream resets.
        for (int n = 0; n < 500; n++) begin
            pc = 12'($urandom);
            pcValid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                step();
                pcValid = ($urandom_range(0, 1) != 0);
                step();
                rst_n = 1'b1;
            end
            step();
        end

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
